// File: rtl/hash_reorder_pkg.sv
// ----------------------------------------------------------------------------
// hash_reorder_pkg
//   Shared types for the hash digest reorder block.
//   - ro_mode_e  : per-digest reorder mode
//   - ro_state_e : collect/emit FSM state
//   - cnt_width  : index counter width for a given digest length (minimum 1)
// ----------------------------------------------------------------------------
package hash_reorder_pkg;

    typedef enum logic [1:0] {
        RO_PASS    = 2'd0,  // words unchanged, original order
        RO_SYMREV  = 2'd1,  // symbols reversed within each word
        RO_BYTEREV = 2'd2,  // bytes reversed within each word
        RO_FULLREV = 2'd3   // whole digest reversed at symbol level
    } ro_mode_e;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } ro_state_e;

    // A single-word digest still needs a 1-bit counter so the vectors are legal.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/word_sym_reverse.sv
// ----------------------------------------------------------------------------
// word_sym_reverse
//   Combinational reversal of the SYM_W-bit symbols inside one WORD_W word:
//   symbol 0 (LSBs) swaps with the top symbol, and so on.
//   Ports:
//     i_word  in  WORD_W  word to reorder
//     o_word  out WORD_W  word with symbol order reversed
// ----------------------------------------------------------------------------
module word_sym_reverse #(
    parameter int WORD_W = 32,
    parameter int SYM_W  = 4
) (
    input  logic [WORD_W-1:0] i_word,
    output logic [WORD_W-1:0] o_word
);

    localparam int N_SYM = WORD_W / SYM_W;

    for (genvar g = 0; g < N_SYM; g++) begin : g_sym
        assign o_word[g*SYM_W +: SYM_W] = i_word[(N_SYM-1-g)*SYM_W +: SYM_W];
    end

endmodule

// File: rtl/hash_digest_reorder.sv
// ----------------------------------------------------------------------------
// hash_digest_reorder
//   Collects one digest of N_WORDS words from a valid/ready stream, then
//   re-emits it with symbol/byte/word reordering selected per digest.
//   Ports:
//     clk        in   1       rising-edge clock
//     rst        in   1       asynchronous active-high reset
//     mode_i     in   2       reorder mode, sampled with the first word
//     in_valid   in   1       input word valid
//     in_ready   out  1       block accepts a word (high in FILL)
//     in_data    in   WORD_W  digest word, word 0 first
//     out_valid  out  1       output word valid (high in DRAIN)
//     out_ready  in   1       downstream accepts the output word
//     out_data   out  WORD_W  reordered output word
//     out_last   out  1       final word of the digest
//     busy       out  1       digest in progress
// ----------------------------------------------------------------------------
module hash_digest_reorder
    import hash_reorder_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int SYM_W   = 4,
    parameter int N_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int              CNT_W    = cnt_width(N_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

    if ((WORD_W % SYM_W) != 0 || (WORD_W % 8) != 0 || N_WORDS < 1) begin : g_bad_params
        $error("hash_digest_reorder: WORD_W must be a multiple of SYM_W and 8, N_WORDS >= 1");
    end

    ro_state_e         r_state;
    ro_mode_e          r_mode;
    logic [CNT_W-1:0]  r_wcnt;
    logic [CNT_W-1:0]  r_rcnt;
    logic [WORD_W-1:0] r_buf [N_WORDS];

    logic [CNT_W-1:0]  w_rd_idx;
    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] w_sym_rev;
    logic [WORD_W-1:0] w_byte_rev;

    // ------------------------------------------------------------------------
    // FSM, counters, mode capture and digest buffer.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FILL;
            r_mode  <= RO_PASS;
            r_wcnt  <= '0;
            r_rcnt  <= '0;
            // NOTE: the buffer is reset (not just overwritten) because out_data is
            // decoded straight from it and must read 0 out of reset.
            for (int i = 0; i < N_WORDS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (in_valid) begin
                        r_buf[r_wcnt] <= in_data;
                        if (r_wcnt == '0) begin
                            r_mode <= ro_mode_e'(mode_i);
                        end
                        if (r_wcnt == LAST_IDX) begin
                            r_wcnt  <= '0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (r_rcnt == LAST_IDX) begin
                            r_rcnt  <= '0;
                            r_state <= ST_FILL;
                        end else begin
                            r_rcnt <= r_rcnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

    // Handshake flags decode directly from the state register, so they carry
    // no path from the inputs.
    assign in_ready  = (r_state == ST_FILL);
    assign out_valid = (r_state == ST_DRAIN);
    // Gated with DRAIN so a single-word digest does not show out_last in FILL.
    assign out_last  = (r_state == ST_DRAIN) && (r_rcnt == LAST_IDX);
    assign busy      = (r_state == ST_DRAIN) || (r_wcnt != '0);

    // ------------------------------------------------------------------------
    // Output path: word select, then per-word reorder.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: combinational blocks assign every output before any branch so
        // no path can leave a value unassigned and infer a latch.
        w_rd_idx = r_rcnt;
        if (r_mode == RO_FULLREV) begin
            w_rd_idx = LAST_IDX - r_rcnt;
        end
    end

    assign w_word = r_buf[w_rd_idx];

    word_sym_reverse #(
        .WORD_W (WORD_W),
        .SYM_W  (SYM_W)
    ) u_sym_rev (
        .i_word (w_word),
        .o_word (w_sym_rev)
    );

    word_sym_reverse #(
        .WORD_W (WORD_W),
        .SYM_W  (8)
    ) u_byte_rev (
        .i_word (w_word),
        .o_word (w_byte_rev)
    );

    // Word reversal plus symbol reversal per word gives a full-digest symbol
    // reversal, so FULLREV reuses the SYMREV datapath.
    always_comb begin
        out_data = w_word;
        case (r_mode)
            RO_PASS:    out_data = w_word;
            RO_SYMREV:  out_data = w_sym_rev;
            RO_BYTEREV: out_data = w_byte_rev;
            RO_FULLREV: out_data = w_sym_rev;
            default:    out_data = w_word;
        endcase
    end

endmodule

// File: tb/tb_hash_digest_reorder.sv
// ----------------------------------------------------------------------------
// tb_hash_digest_reorder
//   Directed bench for hash_digest_reorder (WORD_W=32, SYM_W=4, N_WORDS=8).
//   Expected words are pushed to a scoreboard queue as each digest is sent
//   and popped as the DUT emits them.
// ----------------------------------------------------------------------------
module tb_hash_digest_reorder;

    localparam int WORD_W  = 32;
    localparam int N_WORDS = 8;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t data;
        logic  last;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  [1:0] mode_i;
    logic  in_valid;
    logic  in_ready;
    word_t in_data;
    logic  out_valid;
    logic  out_ready;
    word_t out_data;
    logic  out_last;
    logic  busy;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hash_digest_reorder #(
        .WORD_W  (WORD_W),
        .SYM_W   (4),
        .N_WORDS (N_WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_i    (mode_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic check(input string tag, input word_t obs, input word_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference reorders, written from the definition of each mode.
    function automatic word_t nib_rev(input word_t w);
        word_t r;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = w[4*(7-i) +: 4];
        end
        return r;
    endfunction

    function automatic word_t byte_rev(input word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic word_t ref_word(input logic [1:0] m, input word_t w);
        case (m)
            2'd1, 2'd3: return nib_rev(w);
            2'd2:       return byte_rev(w);
            default:    return w;
        endcase
    endfunction

    // Drive n_send words; mode_first with word 0, mode_rest afterwards.
    // When do_push is set, the expected output digest is queued.
    task automatic send_words(input logic [1:0] mode_first, input logic [1:0] mode_rest,
                              input word_t w [N_WORDS], input int n_send, input bit do_push);
        if (do_push) begin
            for (int k = 0; k < N_WORDS; k++) begin
                exp_t e;
                int   idx;
                idx    = (mode_first == 2'd3) ? (N_WORDS - 1 - k) : k;
                e.data = ref_word(mode_first, w[idx]);
                e.last = (k == N_WORDS - 1);
                sb.push_back(e);
            end
        end
        for (int i = 0; i < n_send; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = w[i];
            mode_i   = (i == 0) ? mode_first : mode_rest;
            check("in_ready_fill", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        mode_i   = 2'($urandom);
        if (n_send > 0) check("busy_after_fill", busy, 1);
        if (n_send == N_WORDS) check("out_valid_latency", out_valid, 1);
    endtask

    // Accept up to max_words outputs with out_ready high pct% of cycles.
    task automatic drain(input int pct, input int max_words);
        int    got     = 0;
        int    cyc     = 0;
        int    want;
        bit    stalled = 1'b0;
        word_t held_d  = '0;
        logic  held_l  = 1'b0;
        want = (sb.size() < max_words) ? sb.size() : max_words;
        while (got < want && cyc < 1000) begin
            out_ready = ($urandom_range(0, 99) < pct);
            check("out_valid_drain", out_valid, 1);
            check("in_ready_drain", in_ready, 0);
            if (stalled) begin
                check("hold_data", out_data, held_d);
                check("hold_last", out_last, held_l);
            end
            if (out_valid && out_ready) begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", out_data, e.data);
                check("out_last", out_last, e.last);
                got++;
                stalled = 1'b0;
            end else begin
                stalled = out_valid;
                held_d  = out_data;
                held_l  = out_last;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        check("drain_count", got, want);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_busy"},      busy,      0);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #2;
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"},  out_last,  0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_out_data"},  out_data,  0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        word_t w [N_WORDS];

        rst       = 1'b1;
        mode_i    = 2'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        pulse_reset("reset");

        // 1: SYMREV, order kept, out_last on word 8
        w = '{32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h4B5A6978,
              32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
        send_words(2'd1, 2'd1, w, N_WORDS, 1'b1);
        drain(100, N_WORDS);
        check_idle("after_symrev");

        // 2: FULLREV, last input word 0x00000001 comes out first as 0x10000000
        w = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00,
              32'h13579BDF, 32'h2468ACE0, 32'hF0E1D2C3, 32'h00000001};
        send_words(2'd3, 2'd3, w, N_WORDS, 1'b1);
        drain(100, N_WORDS);

        // 3: BYTEREV, then PASS
        w = '{32'hAABBCCDD, 32'h00010203, 32'h04050607, 32'h08090A0B,
              32'h0C0D0E0F, 32'h10203040, 32'h50607080, 32'h90A0B0C0};
        send_words(2'd2, 2'd2, w, N_WORDS, 1'b1);
        drain(100, N_WORDS);
        send_words(2'd0, 2'd0, w, N_WORDS, 1'b1);
        drain(100, N_WORDS);

        // 4: Backpressure, 30% ready, across two digests of random data
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N_WORDS; i++) w[i] = $urandom;
            send_words(2'(d + 1), 2'(d + 1), w, N_WORDS, 1'b1);
            drain(30, N_WORDS);
            check_idle("after_backpressure");
        end

        // 5: mode_i changes 1 -> 2 after the first word; digest stays SYMREV
        w = '{32'hA1B2C3D4, 32'hE5F60718, 32'h293A4B5C, 32'h6D7E8F90,
              32'h0BADF00D, 32'hFEEDFACE, 32'h76543210, 32'hFEDCBA98};
        send_words(2'd1, 2'd2, w, N_WORDS, 1'b1);
        drain(100, N_WORDS);

        // 6a: reset after 5 of 8 words; partial digest is discarded
        for (int i = 0; i < N_WORDS; i++) w[i] = 32'hBAD0_0000 | i;
        send_words(2'd0, 2'd0, w, 5, 1'b0);
        pulse_reset("reset_mid_fill");
        w = '{32'h00000010, 32'h00000020, 32'h00000030, 32'h00000040,
              32'h00000050, 32'h00000060, 32'h00000070, 32'h00000080};
        send_words(2'd0, 2'd0, w, N_WORDS, 1'b1);
        drain(100, N_WORDS);
        check_idle("after_fill_reset");

        // 6b: reset after 3 outputs of a digest; remainder never appears
        for (int i = 0; i < N_WORDS; i++) w[i] = 32'h5EED_0000 | (i << 4);
        send_words(2'd3, 2'd3, w, N_WORDS, 1'b1);
        drain(100, 3);
        pulse_reset("reset_mid_drain");
        sb.delete();
        w = '{32'h87654321, 32'h0FEDCBA9, 32'h11111111, 32'h22222222,
              32'h33333333, 32'h44444444, 32'h55555555, 32'h66666666};
        send_words(2'd2, 2'd2, w, N_WORDS, 1'b1);
        drain(60, N_WORDS);
        check_idle("after_drain_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
